// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, fetch FSM encodings and the
// control-transfer opcodes that the core's decode also uses.
package fetch_pkg;

    localparam int FETCH_INSTR_W = 16;
    localparam int FETCH_ADDR_W  = 4;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REFILL = 2'd2
    } fetch_state_e;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_BR  = 4'b1100;

    function automatic logic is_ctrl_xfer(input logic [3:0] opcode);
        return (opcode == OP_JMP) || (opcode == OP_BR);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched {address, instruction} pairs.
// Flush empties it in one cycle; a push into a full queue is accepted only alongside a pop.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 20,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  slot_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = slot_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= din;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: loadable program memory, fetch PC, prefetch queue and valid/ready head.
// Define FETCH_STEP_EN to add the step input that gates every memory read.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ROM_DEPTH   = 16,
    parameter int INSTR_W     = FETCH_INSTR_W,
    parameter int ADDR_W      = FETCH_ADDR_W,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               instr_ready,
`ifdef FETCH_STEP_EN
    input  logic               step,
`endif
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_addr
);

    localparam int QCW = $clog2(QUEUE_DEPTH + 1);

    logic [INSTR_W-1:0] mem_q [ROM_DEPTH];
    logic [INSTR_W-1:0] rdata_q;
    logic [ADDR_W-1:0]  raddr_q;
    logic               inflight_q;
    logic               inflight_epoch_q;
    logic               epoch_q, epoch_d;
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rd_addr;
    logic               issue, flush, push, pop, room, step_ok;
    logic [QCW-1:0]     q_count;
    logic               q_full, q_empty;
    logic [INSTR_W+ADDR_W-1:0] q_dout;

`ifdef FETCH_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign pop  = !q_empty && instr_ready;
    // Reads issued before a redirect carry the old epoch and are dropped on arrival.
    assign push = inflight_q && (inflight_epoch_q == epoch_q);
    // Room counts the in-flight read and credits a same-cycle pop, giving 1/cycle.
    assign room = !(q_full && !pop) &&
                  ((32'(q_count) + 32'(inflight_q)) < (32'(QUEUE_DEPTH) + 32'(pop)));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        issue   = 1'b0;
        flush   = 1'b0;
        rd_addr = pc_q;
        if (load_en) begin
            state_d = ST_LOAD;
            flush   = 1'b1;
        end else if (redirect) begin
            flush   = 1'b1;
            pc_d    = redirect_addr;
            epoch_d = ~epoch_q;
            state_d = ST_REFILL;
        end else begin
            // Leaving LOAD restarts at address 0 without a wasted cycle.
            rd_addr = (state_q == ST_LOAD) ? '0 : pc_q;
            issue   = step_ok && room;
            pc_d    = issue ? rd_addr + 1'b1 : rd_addr;
            state_d = (state_q == ST_REFILL && !issue) ? ST_REFILL : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_FETCH;
            pc_q             <= '0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            raddr_q          <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= issue;
            inflight_epoch_q <= epoch_d;
            if (issue) begin
                raddr_q <= rd_addr;
            end
        end
    end

    // Program memory: contents survive reset; registered read returns old data on collision.
    always_ff @(posedge clk) begin
        if (load_en && !rst) begin
            mem_q[load_addr] <= load_data;
        end
        if (issue) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (INSTR_W + ADDR_W),
        .CW    (QCW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({raddr_q, rdata_q}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign instr_valid = !q_empty;
    assign instruction = q_empty ? '0 : q_dout[INSTR_W-1:0];
    assign instr_addr  = q_empty ? '0 : q_dout[INSTR_W +: ADDR_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: load, streaming, stall, redirects and reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        redirect;
    logic [3:0]  redirect_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [3:0]  instr_addr;
`ifdef FETCH_STEP_EN
    logic        step;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [20:0] obs;
    assign obs = {instr_valid, instr_addr, instruction};

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_ready   (instr_ready),
`ifdef FETCH_STEP_EN
        .step          (step),
`endif
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .instr_addr    (instr_addr)
    );

    function automatic logic [20:0] mk(input logic v, input logic [3:0] a, input logic [15:0] d);
        return {v, a, d};
    endfunction

    function automatic logic [15:0] prog(input int i);
        case (i)
            0: return 16'h1105;
            1: return 16'h1203;
            2: return 16'h2240;
            3: return 16'hF000;
            default: return 16'hA000 | 16'(i);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs !== 21'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, 21'h0);
            end
        end
    endtask

    task automatic test_load_stream();
        logic [20:0] e [6] = '{21'h0, mk(1, 4'd0, 16'h1105), mk(1, 4'd1, 16'h1203),
                               mk(1, 4'd2, 16'h2240), mk(1, 4'd3, 16'hF000), mk(1, 4'd4, 16'hA004)};
        rst = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_data = prog(i);
            tick();
        end
        n_cmp++;
        if (obs !== 21'h0) begin
            n_err++;
            $display("FAIL load_hold: got %h expected %h", obs, 21'h0);
        end
        load_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            $display("stream[%0d]: valid=%0b addr=%0d instr=%h", i, instr_valid, instr_addr, instruction);
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL stream[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [20:0] h = mk(1, 4'd1, 16'h1203);
        logic [20:0] e [12] = '{21'h0, mk(1, 4'd0, 16'h1105), h, h, h, h, h, h,
                                mk(1, 4'd2, 16'h2240), mk(1, 4'd3, 16'hF000),
                                mk(1, 4'd4, 16'hA004), mk(1, 4'd5, 16'hA005)};
        pulse_rst();
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            $display("stall[%0d]: ready=%0b valid=%0b addr=%0d instr=%h", i, instr_ready, instr_valid, instr_addr, instruction);
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL stall[%0d]: got %h expected %h", i, obs, e[i]);
            end
            instr_ready = !(i >= 2 && i < 7);
        end
    endtask

    task automatic test_redirect();
        logic [20:0] e [9] = '{21'h0, mk(1, 4'd0, 16'h1105), mk(1, 4'd1, 16'h1203), 21'h0, 21'h0,
                               mk(1, 4'd14, 16'hA00E), mk(1, 4'd15, 16'hA00F),
                               mk(1, 4'd0, 16'h1105), mk(1, 4'd1, 16'h1203)};
        pulse_rst();
        instr_ready   = 1'b1;
        redirect_addr = 4'hE;
        for (int i = 0; i < 9; i++) begin
            tick();
            $display("redirect[%0d]: valid=%0b addr=%0d instr=%h", i, instr_valid, instr_addr, instruction);
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL redirect[%0d]: got %h expected %h", i, obs, e[i]);
            end
            redirect = (i == 2);
        end
    endtask

    task automatic test_redirect_transfer();
        logic [20:0] e [6] = '{21'h0, mk(1, 4'd0, 16'h1105), 21'h0, 21'h0,
                               mk(1, 4'd5, 16'hA005), mk(1, 4'd6, 16'hA006)};
        pulse_rst();
        instr_ready   = 1'b1;
        redirect_addr = 4'd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            $display("redir_xfer[%0d]: valid=%0b addr=%0d instr=%h", i, instr_valid, instr_addr, instruction);
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL redir_xfer[%0d]: got %h expected %h", i, obs, e[i]);
            end
            redirect = (i == 1);
        end
    endtask

    task automatic test_reset_full();
        logic [20:0] a = mk(1, 4'd0, 16'h1105);
        logic [20:0] e [9] = '{21'h0, a, a, a, 21'h0, 21'h0, a,
                               mk(1, 4'd1, 16'h1203), mk(1, 4'd2, 16'h2240)};
        pulse_rst();
        instr_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            $display("rst_full[%0d]: rst=%0b valid=%0b addr=%0d instr=%h", i, rst, instr_valid, instr_addr, instruction);
            n_cmp++;
            if (obs !== e[i]) begin
                n_err++;
                $display("FAIL rst_full[%0d]: got %h expected %h", i, obs, e[i]);
            end
            rst = (i == 3);
            if (i == 4) instr_ready = 1'b1;
        end
    endtask

`ifdef FETCH_STEP_EN
    task automatic test_step();
        logic [20:0] exp_v;
        step = 1'b0;
        pulse_rst();
        instr_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            step = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                step  = 1'b0;
                exp_v = (c == 1) ? mk(1, 4'(p), prog(p)) : 21'h0;
                $display("step[%0d.%0d]: valid=%0b addr=%0d instr=%h", p, c, instr_valid, instr_addr, instruction);
                n_cmp++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL step[%0d.%0d]: got %h expected %h", p, c, obs, exp_v);
                end
            end
        end
        step = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_ready   = 1'b0;
`ifdef FETCH_STEP_EN
        step          = 1'b1;
`endif
        test_reset();
        test_load_stream();
        test_stall();
        test_redirect();
        test_redirect_transfer();
        test_reset_full();
`ifdef FETCH_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
